cache_tag_assoc: RTL and testbench
==================================

# cache_tag_assoc

Parametrised set-associative tag store for the Y86 predictor-cache data cache. Holds valid, dirty and tag bits per way, performs a registered hit/miss lookup, nominates a replacement victim, and runs a multi-cycle invalidate sweep on request. Sits between the cache controller FSM and the data array; the controller uses `hit_way_o` and `victim_way_o` to steer data-array accesses.

## Interface
- `SETS`, 16, number of sets, power of two ≥ 2; `IDX_W = $clog2(SETS)`
- `WAYS`, 2, associativity: 1, 2 or 4; `WAY_W = max(1, $clog2(WAYS))`
- `TAG_W`, 55, stored tag width

- `clk_i`  in  1  clock, rising edge
- `rst_n_i`  in  1  asynchronous active-low reset
- `lookup_valid_i`  in  1  lookup request
- `lookup_ready_o`  out  1  lookup accepted when valid & ready
- `lookup_index_i`  in  IDX_W  set index
- `lookup_tag_i`  in  TAG_W  compare tag
- `rsp_valid_o`  out  1  one-cycle response strobe
- `hit_o`  out  1  tag match in a valid way
- `hit_way_o`  out  WAY_W  matching way; 0 on miss
- `hit_dirty_o`  out  1  dirty bit of the hit way
- `victim_way_o`  out  WAY_W  replacement way for this set
- `victim_valid_o`, `victim_dirty_o`  out  1 each  victim state bits
- `victim_tag_o`  out  TAG_W  victim tag (for write-back address)
- `upd_we_i`  in  1  write one way entry
- `upd_index_i`  in  IDX_W; `upd_way_i`  in  WAY_W; `upd_tag_i`  in  TAG_W; `upd_valid_i`, `upd_dirty_i`  in  1 each
- `flush_req_i`  in  1  start invalidate sweep
- `flush_busy_o`  out  1  sweep in progress

## Operation
- Storage: valid, dirty and tag per (set, way). Reset clears every valid and dirty bit and all replacement state; tag fields are not reset.
- Lookup accepted in cycle N: compare against all ways of `lookup_index_i` using the state before the N edge; results are registered into the response outputs at the N edge.
- Hit: exactly one valid way matches. Multiple matches are a controller error; the lowest-numbered way is reported.
- Victim: lowest-numbered invalid way if any exist; otherwise the replacement policy's way (see Configuration).
- Replacement touch: an accepted hit marks `hit_way` MRU; an `upd_we_i` with `upd_valid_i=1` marks `upd_way_i` MRU. When both touch the same set in one cycle, the update is applied last and wins.
- Update: `upd_we_i` overwrites all three fields at the edge. Writing `upd_valid_i=0` invalidates the entry.
- Flush FSM, states IDLE and SWEEP:
  - IDLE→SWEEP on `flush_req_i`.
  - SWEEP clears valid, dirty and replacement state for set `cnt`, then increments `cnt` from 0 up to SETS-1, one set per cycle.
  - SWEEP→IDLE after the set SETS-1 is cleared.
- During SWEEP: `lookup_ready_o=0`, `upd_we_i` is ignored, and `flush_req_i` is ignored. The sweep does not write back dirty lines; the controller must do that first.

## Timing
- `lookup_ready_o = ~flush_busy_o`, combinational.
- Lookup latency is 1 cycle. `rsp_valid_o` is high for exactly one cycle per accepted lookup, and back-to-back lookups are supported every cycle.
- Read-during-write: a lookup and an update in the same cycle on the same entry return the pre-write contents. The write is visible to a lookup issued the next cycle.
- Flush: `flush_req_i` sampled in cycle N gives `flush_busy_o=1` from N+1 through N+SETS, and a lookup is accepted again in cycle N+SETS+1. A lookup presented in cycle N itself is still accepted.
- Reset values: all outputs 0 except `lookup_ready_o=1`.
- Asynchronous reset mid-sweep returns the FSM to IDLE with `cnt=0`.

## Configuration
- `CACHE_TAG_PLRU_EN` defined: per-set tree pseudo-LRU with WAYS-1 bits per set.
  - Victim is the leaf reached by following the tree bits.
  - A touch sets the bits on its path to point away from the touched way.
  - WAYS=1 needs no storage.
- Not defined: a single global WAY_W-bit round-robin pointer.
  - Victim is the pointer value.
  - The pointer increments modulo WAYS on every `upd_we_i` with `upd_valid_i=1`.
  - Hits do not change it.

## Test plan
All scenarios use SETS=16, WAYS=2, TAG_W=55.
- Reset, then look up idx 3 tag 0x1A → next cycle `rsp_valid_o=1`, `hit_o=0`, `victim_way_o=0`, `victim_valid_o=0`.
- Fill idx 3 way 1 tag 0x1A dirty=1, then look up 0x1A → `hit_o=1`, `hit_way_o=1`, `hit_dirty_o=1`.
- Same-cycle update and lookup on idx 5 tag 0x22 → miss reported; the lookup on the following cycle hits.
- PLRU: fill idx 7 ways 0 and 1 with tags 0x10 and 0x11, then hit 0x10 → `victim_way_o=1`, `victim_tag_o=0x11`. Round-robin build: after two fills, victim is 0.
- Flush while idx 2 and 9 are valid → `flush_busy_o` high for 16 cycles and `lookup_ready_o=0` over the same cycles. Afterwards, lookups of both sets miss with `victim_valid_o=0`.
- Assert `rst_n_i` low during cycle 4 of a sweep → `flush_busy_o=0` immediately and all entries invalid.

Source files
------------

// File: rtl/cache_tag_assoc.sv
// cache_tag_assoc: set-associative tag store (valid/dirty/tag per way).
// Provides a registered lookup with victim selection and a one-set-per-cycle
// invalidate sweep.
// Optional macro CACHE_TAG_PLRU_EN selects per-set tree pseudo-LRU
// replacement. Without it, replacement uses a global round-robin pointer.
module cache_tag_assoc #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int TAG_W = 55,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             lookup_valid_i,
  output logic             lookup_ready_o,
  input  logic [IDX_W-1:0] lookup_index_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             rsp_valid_o,
  output logic             hit_o,
  output logic [WAY_W-1:0] hit_way_o,
  output logic             hit_dirty_o,
  output logic [WAY_W-1:0] victim_way_o,
  output logic             victim_valid_o,
  output logic             victim_dirty_o,
  output logic [TAG_W-1:0] victim_tag_o,
  input  logic             upd_we_i,
  input  logic [IDX_W-1:0] upd_index_i,
  input  logic [WAY_W-1:0] upd_way_i,
  input  logic [TAG_W-1:0] upd_tag_i,
  input  logic             upd_valid_i,
  input  logic             upd_dirty_i,
  input  logic             flush_req_i,
  output logic             flush_busy_o
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                         state_q, state_nxt;
  logic [IDX_W-1:0]               cnt_q, cnt_nxt;
  logic                           busy;
  logic [SETS-1:0][WAYS-1:0]      valid_q, dirty_q;
  logic [TAG_W-1:0]               tag_q [SETS][WAYS];

  logic                           acc, upd_en;
  logic                           hit;
  logic [WAY_W-1:0]               hit_way, vic_way, pol_way;
  logic                           hit_dirty;

  assign lookup_ready_o = ~busy;
  assign flush_busy_o   = busy;
  assign acc            = lookup_valid_i & ~busy;
  assign upd_en         = upd_we_i & ~busy;

  // Sweep FSM state and set counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Sweep next-state: walk sets 0..SETS-1, then return to IDLE
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    busy      = 1'b0;
    case (state_q)
      IDLE:  if (flush_req_i) state_nxt = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Compare all ways; descending scan lets the lowest way win both searches
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_dirty = 1'b0;
    vic_way   = pol_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lookup_index_i][w] && tag_q[lookup_index_i][w] == lookup_tag_i) begin
        hit       = 1'b1;
        hit_way   = WAY_W'(w);
        hit_dirty = dirty_q[lookup_index_i][w];
      end
      if (!valid_q[lookup_index_i][w]) vic_way = WAY_W'(w);
    end
  end

`ifdef CACHE_TAG_PLRU_EN
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;
  logic [SETS-1:0][PW-1:0] plru_q;
  logic [PW-1:0]           plru_hit, plru_upd_base;

  // Follow tree bits: bit0 is the root, bit1/bit2 pick within each half
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] bits);
    logic [2:0] b;
    logic [1:0] v;
    b = 3'(bits);
    v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    if (WAYS == 2) v = {1'b0, b[0]};
    if (WAYS == 1) v = 2'b00;
    return WAY_W'(v);
  endfunction

  // Point every node on the touched way's path away from it
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits,
                                               input logic [WAY_W-1:0] way);
    logic [2:0] b;
    logic [1:0] w;
    b = 3'(bits);
    w = 2'(way);
    if (WAYS == 4) begin
      b[0] = ~w[1];
      if (w[1]) b[2] = ~w[0];
      else      b[1] = ~w[0];
    end else if (WAYS == 2) begin
      b[0] = ~w[0];
    end else begin
      b = 3'b000;
    end
    return PW'(b);
  endfunction

  assign pol_way       = plru_victim(plru_q[lookup_index_i]);
  assign plru_hit      = plru_touch(plru_q[lookup_index_i], hit_way);
  assign plru_upd_base = (acc && hit && lookup_index_i == upd_index_i) ? plru_hit
                                                                        : plru_q[upd_index_i];

  // Tree state: hit touch first, a same-set update touch layered on top
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      plru_q <= '0;
    end else if (busy) begin
      plru_q[cnt_q] <= '0;
    end else begin
      if (acc && hit) plru_q[lookup_index_i] <= plru_hit;
      if (upd_en && upd_valid_i) plru_q[upd_index_i] <= plru_touch(plru_upd_base, upd_way_i);
    end
  end
`else
  logic [WAY_W-1:0] rr_q;

  assign pol_way = rr_q;

  // Global round-robin pointer advances on each valid fill
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q <= '0;
    end else if (upd_en && upd_valid_i) begin
      if (rr_q == WAY_W'(WAYS - 1)) rr_q <= '0;
      else                          rr_q <= rr_q + 1'b1;
    end
  end
`endif

  // Valid/dirty bits: sweep clears one set per cycle, else apply update
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (busy) begin
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
    end else if (upd_en) begin
      valid_q[upd_index_i][upd_way_i] <= upd_valid_i;
      dirty_q[upd_index_i][upd_way_i] <= upd_dirty_i;
    end
  end

  // Tag array has no reset; entries are meaningless until valid
  always_ff @(posedge clk_i) begin
    if (upd_en) tag_q[upd_index_i][upd_way_i] <= upd_tag_i;
  end

  // Register lookup results; outputs hold between responses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_o    <= 1'b0;
      hit_o          <= 1'b0;
      hit_way_o      <= '0;
      hit_dirty_o    <= 1'b0;
      victim_way_o   <= '0;
      victim_valid_o <= 1'b0;
      victim_dirty_o <= 1'b0;
      victim_tag_o   <= '0;
    end else begin
      rsp_valid_o <= acc;
      if (acc) begin
        hit_o          <= hit;
        hit_way_o      <= hit_way;
        hit_dirty_o    <= hit_dirty;
        victim_way_o   <= vic_way;
        victim_valid_o <= valid_q[lookup_index_i][vic_way];
        victim_dirty_o <= dirty_q[lookup_index_i][vic_way];
        victim_tag_o   <= tag_q[lookup_index_i][vic_way];
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_assoc.sv
// tb_cache_tag_assoc: scoreboard bench for cache_tag_assoc with an
// array-based reference model and randomized traffic.
module tb_cache_tag_assoc;
  localparam int SETS = 16, WAYS = 2, TAG_W = 55, IDX_W = 4, WAY_W = 1;

  logic             clk_i = 1'b0, rst_n_i = 1'b0;
  logic             lookup_valid_i = 1'b0, lookup_ready_o;
  logic [IDX_W-1:0] lookup_index_i = '0;
  logic [TAG_W-1:0] lookup_tag_i = '0;
  logic             rsp_valid_o, hit_o, hit_dirty_o;
  logic [WAY_W-1:0] hit_way_o, victim_way_o;
  logic             victim_valid_o, victim_dirty_o;
  logic [TAG_W-1:0] victim_tag_o;
  logic             upd_we_i = 1'b0, upd_valid_i = 1'b0, upd_dirty_i = 1'b0;
  logic [IDX_W-1:0] upd_index_i = '0;
  logic [WAY_W-1:0] upd_way_i = '0;
  logic [TAG_W-1:0] upd_tag_i = '0;
  logic             flush_req_i = 1'b0, flush_busy_o;

  cache_tag_assoc #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_index_i(lookup_index_i), .lookup_tag_i(lookup_tag_i),
    .rsp_valid_o(rsp_valid_o), .hit_o(hit_o), .hit_way_o(hit_way_o),
    .hit_dirty_o(hit_dirty_o), .victim_way_o(victim_way_o),
    .victim_valid_o(victim_valid_o), .victim_dirty_o(victim_dirty_o),
    .victim_tag_o(victim_tag_o), .upd_we_i(upd_we_i), .upd_index_i(upd_index_i),
    .upd_way_i(upd_way_i), .upd_tag_i(upd_tag_i), .upd_valid_i(upd_valid_i),
    .upd_dirty_i(upd_dirty_i), .flush_req_i(flush_req_i), .flush_busy_o(flush_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         hit;
    int         hw;
    bit         hd;
    int         vw;
    bit         vv;
    bit         vd;
    logic [TAG_W-1:0] vt;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;

  // Reference model: plain per-entry arrays plus replacement bookkeeping
  bit               mv [SETS][WAYS];
  bit               md [SETS][WAYS];
  logic [TAG_W-1:0] mt [SETS][WAYS];
  int               rr;
  int               lru [SETS];  // least-recently-used way per set

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      lru[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0;
        md[s][w] = 0;
      end
    end
    rr = 0;
  endtask

  function automatic rsp_t model_lookup(input int idx, input logic [TAG_W-1:0] tag);
    rsp_t r;
    bit   found_inv;
    r.hit = 0; r.hw = 0; r.hd = 0;
    for (int w = 0; w < WAYS; w++)
      if (!r.hit && mv[idx][w] && mt[idx][w] == tag) begin
        r.hit = 1; r.hw = w; r.hd = md[idx][w];
      end
    found_inv = 0;
    r.vw = 0;
    for (int w = 0; w < WAYS; w++)
      if (!found_inv && !mv[idx][w]) begin
        found_inv = 1; r.vw = w;
      end
`ifdef CACHE_TAG_PLRU_EN
    if (!found_inv) r.vw = lru[idx];
`else
    if (!found_inv) r.vw = rr;
`endif
    r.vv = mv[idx][r.vw];
    r.vd = md[idx][r.vw];
    r.vt = mt[idx][r.vw];
    return r;
  endfunction

  // Monitor: every response strobe must match the oldest expectation
  always @(negedge clk_i) begin
    if (rst_n_i && rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("hit", hit_o, mon_e.hit);
        chk("hit_way", hit_way_o, mon_e.hw);
        chk("hit_dirty", hit_dirty_o, mon_e.hd);
        chk("victim_way", victim_way_o, mon_e.vw);
        chk("victim_valid", victim_valid_o, mon_e.vv);
        chk("victim_dirty", victim_dirty_o, mon_e.vd);
        if (mon_e.vv) chk("victim_tag", victim_tag_o, mon_e.vt);
      end
    end
  end

  // One accepted cycle; called at posedge+1, returns at next posedge+1
  task automatic step(input bit lv, input int li, input logic [TAG_W-1:0] lt,
                      input bit we, input int ui, input int uw,
                      input logic [TAG_W-1:0] ut, input bit uv, input bit ud,
                      input bit fr);
    rsp_t r;
    lookup_valid_i = lv; lookup_index_i = IDX_W'(li); lookup_tag_i = lt;
    upd_we_i = we; upd_index_i = IDX_W'(ui); upd_way_i = WAY_W'(uw);
    upd_tag_i = ut; upd_valid_i = uv; upd_dirty_i = ud; flush_req_i = fr;
    if (lv) begin
      r = model_lookup(li, lt);
      exp_q.push_back(r);
`ifdef CACHE_TAG_PLRU_EN
      if (r.hit) lru[li] = (r.hw == 0) ? 1 : 0;
`endif
    end
    if (we) begin
      mv[ui][uw] = uv; md[ui][uw] = ud; mt[ui][uw] = ut;
      if (uv) begin
`ifdef CACHE_TAG_PLRU_EN
        lru[ui] = (uw == 0) ? 1 : 0;
`else
        rr = (rr + 1) % WAYS;
`endif
      end
    end
    @(posedge clk_i); #1;
    lookup_valid_i = 0; upd_we_i = 0; flush_req_i = 0;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic look(input int i, input logic [TAG_W-1:0] t); step(1, i, t, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic fill(input int i, input int w, input logic [TAG_W-1:0] t, input bit d);
    step(0, 0, 0, 1, i, w, t, 1, d, 0);
  endtask

  // Sweep cycles: requests of every kind are presented and must be ignored
  task automatic sweep_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      lookup_valid_i = 1; lookup_index_i = IDX_W'($urandom_range(0, SETS - 1));
      upd_we_i = 1; upd_valid_i = 1; upd_index_i = IDX_W'($urandom_range(0, SETS - 1));
      upd_tag_i = TAG_W'($urandom_range(0, 3));
      flush_req_i = $urandom_range(0, 1);
      chk("sweep_busy", flush_busy_o, 1);
      chk("sweep_ready", lookup_ready_o, 0);
      @(posedge clk_i); #1;
    end
    lookup_valid_i = 0; upd_we_i = 0; flush_req_i = 0;
  endtask

  task automatic flush_full();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    sweep_cycles(SETS);
    chk("sweep_done_busy", flush_busy_o, 0);
    chk("sweep_done_ready", lookup_ready_o, 1);
    model_reset_keep_rr();
  endtask

  task automatic model_reset_keep_rr();
    int keep;
    keep = rr;
    model_reset();
    rr = keep;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #12;
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_ready", lookup_ready_o, 1);
    chk("rst_busy", flush_busy_o, 0);
    chk("rst_hit", hit_o, 0);
    chk("rst_victim_tag", victim_tag_o, 0);
    @(negedge clk_i); rst_n_i = 1;
    @(posedge clk_i); #1;

    // Cold lookup, fill, then hit with dirty
    look(3, 55'h1A);
    fill(3, 1, 55'h1A, 1);
    look(3, 55'h1A);
    // Same-cycle update and lookup returns old contents; next cycle hits
    step(1, 5, 55'h22, 1, 5, 0, 55'h22, 1, 0, 0);
    look(5, 55'h22);
    // Two fills in a set, hit way 0, then see the victim move
    fill(7, 0, 55'h10, 0);
    fill(7, 1, 55'h11, 0);
    look(7, 55'h10);
    look(7, 55'h10);
    look(7, 55'h77);
    // Back-to-back lookups every cycle
    for (int k = 0; k < 4; k++) look(k, 55'h1A);
    // Flush with sets 2 and 9 valid
    fill(2, 0, 55'h5, 1);
    fill(9, 1, 55'h6, 0);
    look(2, 55'h5);
    flush_full();
    look(2, 55'h5);
    look(9, 55'h6);

    // Reset in the middle of a sweep
    fill(12, 0, 55'h3, 1);
    fill(15, 1, 55'h4, 1);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    sweep_cycles(3);
    #2 rst_n_i = 0;
    #1;
    chk("midrst_busy", flush_busy_o, 0);
    chk("midrst_ready", lookup_ready_o, 1);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk_i); rst_n_i = 1;
    @(posedge clk_i); #1;
    look(12, 55'h3);
    look(15, 55'h4);
    look(2, 55'h5);

    // Randomized traffic over a few sets and tags to force hits and evictions
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        flush_full();
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 3), TAG_W'($urandom_range(0, 3)),
             $urandom_range(0, 9) < 4, $urandom_range(0, 3), $urandom_range(0, WAYS - 1),
             TAG_W'($urandom_range(0, 3)), $urandom_range(0, 7) != 0,
             $urandom_range(0, 1), 0);
      end
    end
    idle();
    idle();
    chk("pending_rsp", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
